// File: rtl/matrix_mul_stream.sv
// Streaming matrix multiplier: C = A(MxK) * B(KxN), with dimensions chosen at run time up to MAX_N.
// Operands are loaded row-major into local buffers. Each output element is then issued once
// to MAX_N parallel multiplier lanes, which feed a registered binary adder tree.

// One multiplier lane: a registered signed product, sign-extended to the accumulator width.
module mm_lane #(
  parameter int DW    = 16,
  parameter int ACC_W = 35
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    en,
  input  logic                    use_term,
  input  logic signed [DW-1:0]    a,
  input  logic signed [DW-1:0]    b,
  output logic signed [ACC_W-1:0] prod
);
  logic signed [2*DW-1:0] p;
  assign p = a * b;

  // Multiply stage; terms beyond K are forced to zero so the tree sum stays exact.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn)   prod <= '0;
    else if (en) prod <= use_term ? {{(ACC_W-2*DW){p[2*DW-1]}}, p} : '0;
endmodule

module matrix_mul_stream #(
  parameter int DW    = 16,
  parameter int MAX_N = 8,
  parameter int ACC_W = 2*DW + $clog2(MAX_N)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [3:0]       dim_m,
  input  logic [3:0]       dim_k,
  input  logic [3:0]       dim_n,
  output logic             ren,
  output logic             raddr,
  input  logic [DW-1:0]    rdata,
  input  logic             rvalid,
  output logic [ACC_W-1:0] wdata,
  output logic             wen,
  input  logic             wready,
  output logic             busy,
  output logic             finish,
  output logic             err,
  output logic [6:0]       out_cnt
);
  localparam int         IW     = $clog2(MAX_N);
  localparam int         STAGES = 1 + IW;   // multiply stage + adder-tree levels
  localparam logic [3:0] MAXD   = 4'(MAX_N);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, CALC, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [3:0]              m_q, k_q, n_q;
  logic [IW-1:0]           lr, lc;        // load row/col
  logic [IW-1:0]           ci, cj;        // issue row/col
  logic [STAGES:1]         vld_pipe;
  logic signed [DW-1:0]    a_buf [MAX_N][MAX_N];
  logic signed [DW-1:0]    b_buf [MAX_N][MAX_N];
  logic signed [ACC_W-1:0] prod [MAX_N];
  logic signed [ACC_W-1:0] sum_node [MAX_N-1];   // heap-ordered tree; node 0 is the root

  logic       dims_ok, go, consume, ld_last, stall, adv, issue, iss_last, acc, cnt_last;
  logic [3:0] ld_rows, ld_cols;
  logic [6:0] mn;

  assign dims_ok = (dim_m != 4'd0) && (dim_m <= MAXD) &&
                   (dim_k != 4'd0) && (dim_k <= MAXD) &&
                   (dim_n != 4'd0) && (dim_n <= MAXD);
  assign go      = (state == IDLE) && start && dims_ok;

  // ren is derived from state, so it falls at the same edge that consumes the last element.
  assign ren     = (state == LOAD_A) || (state == LOAD_B);
  assign raddr   = (state == LOAD_B);
  assign consume = ren && rvalid;
  assign ld_rows = raddr ? k_q : m_q;
  assign ld_cols = raddr ? n_q : k_q;
  assign ld_last = consume && (4'(lr) == ld_rows - 4'd1) && (4'(lc) == ld_cols - 4'd1);

  // A stalled head-of-line result freezes everything behind it.
  assign wen      = vld_pipe[STAGES];
  assign stall    = wen && !wready;
  assign adv      = !stall;
  assign acc      = wen && wready;
  assign issue    = (state == CALC) && adv;
  assign iss_last = issue && (4'(ci) == m_q - 4'd1) && (4'(cj) == n_q - 4'd1);
  assign mn       = 7'(m_q) * 7'(n_q);
  assign cnt_last = acc && (out_cnt + 7'd1 == mn);

  assign wdata  = wen ? sum_node[0] : '0;
  assign busy   = (state != IDLE);
  assign finish = (state == DONE);

  // State register
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (go)       state_nxt = LOAD_A;
      LOAD_A:  if (ld_last)  state_nxt = LOAD_B;
      LOAD_B:  if (ld_last)  state_nxt = CALC;
      CALC:    if (iss_last) state_nxt = DRAIN;
      DRAIN:   if (cnt_last) state_nxt = DONE;
      DONE:                  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Latch the job dimensions on a legal start; a rejected start only pulses err.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      m_q <= '0; k_q <= '0; n_q <= '0; err <= 1'b0;
    end else begin
      err <= (state == IDLE) && start && !dims_ok;
      if (go) begin
        m_q <= dim_m; k_q <= dim_k; n_q <= dim_n;
      end
    end

  // Row-major load position; wraps to zero at the end of A, ready for B.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      lr <= '0; lc <= '0;
    end else if (go) begin
      lr <= '0; lc <= '0;
    end else if (consume) begin
      if (4'(lc) == ld_cols - 4'd1) begin
        lc <= '0;
        lr <= (4'(lr) == ld_rows - 4'd1) ? '0 : lr + 1'b1;
      end else begin
        lc <= lc + 1'b1;
      end
    end

  // Operand buffers; contents outside the loaded dimensions are don't-care.
  always_ff @(posedge clk)
    if (consume) begin
      if (raddr) b_buf[lr][lc] <= rdata;
      else       a_buf[lr][lc] <= rdata;
    end

  // Row-major output issue position.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      ci <= '0; cj <= '0;
    end else if (go) begin
      ci <= '0; cj <= '0;
    end else if (issue) begin
      if (4'(cj) == n_q - 4'd1) begin
        cj <= '0;
        ci <= (4'(ci) == m_q - 4'd1) ? '0 : ci + 1'b1;
      end else begin
        cj <= cj + 1'b1;
      end
    end

  // Valid shift register that tracks issued outputs through the multiply stage and the tree.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn)    vld_pipe <= '0;
    else if (adv) vld_pipe <= {vld_pipe[STAGES-1:1], issue};

  // Count accepted results for this job.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn)    out_cnt <= '0;
    else if (go)  out_cnt <= '0;
    else if (acc) out_cnt <= out_cnt + 7'd1;

  for (genvar t = 0; t < MAX_N; t++) begin : g_lane
    mm_lane #(.DW(DW), .ACC_W(ACC_W)) u_lane (
      .clk      (clk),
      .rstn     (rstn),
      .en       (adv),
      .use_term (4'(t) < k_q),
      .a        (a_buf[ci][t]),
      .b        (b_buf[t][cj]),
      .prod     (prod[t])
    );
  end

  for (genvar p = 0; p < MAX_N-1; p++) begin : g_node
    logic signed [ACC_W-1:0] l_in, r_in;
    if (2*p+1 >= MAX_N-1) begin : g_leaf
      assign l_in = prod[2*p+1-(MAX_N-1)];
      assign r_in = prod[2*p+2-(MAX_N-1)];
    end else begin : g_inner
      assign l_in = sum_node[2*p+1];
      assign r_in = sum_node[2*p+2];
    end
    // One registered adder per tree node, advancing in lockstep with the valid pipe.
    always_ff @(posedge clk or negedge rstn)
      if (!rstn)    sum_node[p] <= '0;
      else if (adv) sum_node[p] <= l_in + r_in;
  end
endmodule

// File: tb/tb_matrix_mul_stream.sv
// Bench for matrix_mul_stream: directed cases plus randomized jobs against a plain matrix-product model.
module tb_matrix_mul_stream;
  localparam int DW = 16, MAX_N = 8, ACC_W = 2*DW + $clog2(MAX_N);

  logic             clk = 1'b0, rstn = 1'b0, start = 1'b0;
  logic [3:0]       dim_m = '0, dim_k = '0, dim_n = '0;
  logic             ren, raddr, rvalid = 1'b0, wen, wready = 1'b1;
  logic [DW-1:0]    rdata = '0;
  logic [ACC_W-1:0] wdata;
  logic             busy, finish, err;
  logic [6:0]       out_cnt;

  int tests = 0, failed = 0;
  int a_m [8][8];
  int b_m [8][8];

  matrix_mul_stream #(.DW(DW), .MAX_N(MAX_N)) dut (
    .clk(clk), .rstn(rstn), .start(start), .dim_m(dim_m), .dim_k(dim_k), .dim_n(dim_n),
    .ren(ren), .raddr(raddr), .rdata(rdata), .rvalid(rvalid), .wdata(wdata), .wen(wen),
    .wready(wready), .busy(busy), .finish(finish), .err(err), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ren"}, ren, 0);
    check({tag, "_raddr"}, raddr, 0);
    check({tag, "_wen"}, wen, 0);
    check({tag, "_wdata"}, longint'(wdata), 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_finish"}, finish, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_out_cnt"}, out_cnt, 0);
  endtask

  // mode[0]: random rvalid gaps, mode[1]: random wready, mode[2]: stall the 2nd result 3 cycles.
  // abort_at > 0: apply reset that many cycles after B is fully read, then return.
  task automatic run_job(input int m, input int k, input int n, input int mode, input int abort_at);
    longint exp_q[$];
    int ia = 0, ib = 0, cyc = 0, acc_n = 0, first_acc = -1, last_acc = -1, fin_cyc = -1;
    int held = 0, post = 0;
    for (int i = 0; i < m; i++)
      for (int j = 0; j < n; j++) begin
        longint s = 0;
        for (int t = 0; t < k; t++) s += longint'(a_m[i][t]) * longint'(b_m[t][j]);
        exp_q.push_back(s);
      end
    @(negedge clk);
    start = 1'b1; dim_m = 4'(m); dim_k = 4'(k); dim_n = 4'(n);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    while (fin_cyc < 0 && cyc < 4000) begin
      if (abort_at > 0 && ib == k*n) begin
        if (post == abort_at) begin
          rstn = 1'b0; rvalid = 1'b0; wready = 1'b1;
          #1 check_all_zero("in_reset");
          @(negedge clk);
          check_all_zero("in_reset_2");
          rstn = 1'b1;
          return;
        end
        post++;
      end
      rvalid = mode[0] ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!raddr) rdata = (ia < m*k) ? 16'(a_m[ia/k][ia%k]) : '0;
      else        rdata = (ib < k*n) ? 16'(b_m[ib/n][ib%n]) : '0;
      wready = mode[1] ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (mode[2] && wen && acc_n == 1 && held < 3) begin
        wready = 1'b0; held++;
      end
      #1;
      if (ren && rvalid) begin
        check("no_overread", longint'(ia < m*k || ib < k*n), 1);
        check("raddr", raddr, (ia < m*k) ? 0 : 1);
        if (!raddr) ia++; else ib++;
      end
      if (wen) begin
        check("wdata", longint'($signed(wdata)), (exp_q.size() > 0) ? exp_q[0] : -1);
        if (wready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          if (first_acc < 0) first_acc = cyc;
          last_acc = cyc;
          acc_n++;
        end
      end
      if (finish) begin
        fin_cyc = cyc;
        check("out_cnt_at_finish", out_cnt, m*n);
      end
      @(negedge clk);
      cyc++;
    end
    check("finish_seen", longint'(fin_cyc >= 0), 1);
    check("a_reads", ia, m*k);
    check("b_reads", ib, k*n);
    check("results_left", exp_q.size(), 0);
    check("finish_after_last", fin_cyc, last_acc + 1);
    if (mode == 0) check("back_to_back", last_acc - first_acc, m*n - 1);
    check("finish_one_cycle", finish, 0);
    check("idle_after_job", busy, 0);
    check("out_cnt_hold", out_cnt, m*n);
  endtask

  task automatic load_case1();
    a_m[0][0] = 1; a_m[0][1] = 2; a_m[1][0] = 3; a_m[1][1] = 4;
    b_m[0][0] = 5; b_m[0][1] = 6; b_m[1][0] = 7; b_m[1][1] = 8;
  endtask

  initial begin
    // Reset state
    #12 check_all_zero("reset");
    @(negedge clk); rstn = 1'b1;

    // Case 1: 2x2x2 at full rate
    load_case1();
    run_job(2, 2, 2, 0, 0);

    // Case 2: 1x3 * 3x2
    a_m[0][0] = 1; a_m[0][1] = 2; a_m[0][2] = 3;
    b_m[0][0] = 1; b_m[0][1] = 0; b_m[1][0] = 0; b_m[1][1] = 1; b_m[2][0] = 1; b_m[2][1] = 1;
    run_job(1, 3, 2, 0, 0);

    // Case 3: all operands at the most negative value, full size
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin a_m[i][j] = -32768; b_m[i][j] = -32768; end
    run_job(8, 8, 8, 0, 0);

    // Case 4: backpressure on the 2nd result
    load_case1();
    run_job(2, 2, 2, 4, 0);

    // Case 5: illegal dimensions, then a legal job
    @(negedge clk); start = 1'b1; dim_m = 4'd2; dim_k = 4'd0; dim_n = 4'd2;
    @(negedge clk); start = 1'b0;
    check("err_k0", err, 1); check("err_k0_busy", busy, 0); check("err_k0_ren", ren, 0);
    @(negedge clk);
    check("err_k0_pulse", err, 0); check("err_k0_idle", busy, 0);
    start = 1'b1; dim_m = 4'd2; dim_k = 4'd2; dim_n = 4'd9;
    @(negedge clk); start = 1'b0;
    check("err_n9", err, 1); check("err_n9_busy", busy, 0); check("err_n9_ren", ren, 0);
    @(negedge clk);
    check("err_n9_pulse", err, 0);
    run_job(2, 2, 2, 0, 0);

    // Case 6: reset in the middle of the computation, then rerun case 1
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin a_m[i][j] = -32768; b_m[i][j] = -32768; end
    run_job(8, 8, 8, 0, 3);
    load_case1();
    run_job(2, 2, 2, 0, 0);

    // Randomized jobs with random gaps and backpressure, including the size extremes
    for (int r = 0; r < 8; r++) begin
      int m, k, n;
      m = (r == 0) ? 1 : (r == 1) ? 8 : int'($urandom_range(1, 8));
      k = (r == 0) ? 1 : (r == 1) ? 8 : int'($urandom_range(1, 8));
      n = (r == 0) ? 1 : (r == 1) ? 8 : int'($urandom_range(1, 8));
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++) begin
          a_m[i][j] = int'($urandom_range(0, 65535)) - 32768;
          b_m[i][j] = int'($urandom_range(0, 65535)) - 32768;
        end
      run_job(m, k, n, 3, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
